// File: rtl/tick_time_counter.sv
// -----------------------------------------------------------------------------
// tick_time_counter
//
// Receiving end of the one-second toggle produced by the clock generator.
// tick_in is synchronised into the clk_in domain; every rising or falling edge
// of it is one second. The block keeps a 24-hour hour:min:sec time, offers a
// valid/ready time-set port and pulses once per counted second and once per
// day wrap. The outputs feed the display/decoder stage.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on tick_in (2..4)
//   HOUR_MAX     hours per day; hour counts 0..HOUR_MAX-1
//
// Ports:
//   clk_in      system clock
//   rst_n       asynchronous active-low reset
//   tick_in     toggling one-second input, asynchronous to clk_in
//   run         1 = count seconds, 0 = consume ticks without counting
//   set_valid   time-set request
//   set_ready   block accepts set requests (after the post-reset settle)
//   set_hour/set_min/set_sec   time to load
//   set_err     1-cycle pulse: an accepted set request held an illegal value
//   hour/min/sec               current time, binary
//   sec_pulse   1-cycle pulse on each counted second
//   day_pulse   1-cycle pulse on the wrap HOUR_MAX-1:59:59 -> 00:00:00
//
// Optional build macro TICK_TIME_COUNTER_ALARM_EN adds:
//   alarm_arm, alarm_hour, alarm_min (inputs), alarm_hit (output): 1-cycle
//   pulse when a counted second lands on alarm_hour:alarm_min:00 while armed.
// -----------------------------------------------------------------------------
module tick_time_counter #(
  parameter int SYNC_STAGES = 2,
  parameter int HOUR_MAX    = 24
) (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       tick_in,
  input  logic       run,
  input  logic       set_valid,
  output logic       set_ready,
  input  logic [4:0] set_hour,
  input  logic [5:0] set_min,
  input  logic [5:0] set_sec,
  output logic       set_err,
`ifdef TICK_TIME_COUNTER_ALARM_EN
  input  logic       alarm_arm,
  input  logic [4:0] alarm_hour,
  input  logic [5:0] alarm_min,
  output logic       alarm_hit,
`endif
  output logic [4:0] hour,
  output logic [5:0] min,
  output logic [5:0] sec,
  output logic       sec_pulse,
  output logic       day_pulse
);

  localparam logic [4:0] HOUR_LAST = 5'(HOUR_MAX - 1);
  localparam logic [2:0] WAIT_LAST = 3'(SYNC_STAGES);
  localparam logic [5:0] MS_LAST   = 6'd59;

  typedef enum logic {
    ST_WAIT_SYNC,
    ST_RUN
  } state_t;

  state_t                 state;
  logic [2:0]             wait_cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sync_val;
  logic                   tick_edge;
  logic                   sec_tick;
  logic                   set_accept;
  logic                   set_legal;

  logic                   sec_wrap;
  logic                   min_wrap;
  logic                   day_wrap;
  logic [5:0]             sec_nxt;
  logic [5:0]             min_nxt;
  logic [4:0]             hour_nxt;

  // ---------------------------------------------------------------------------
  // Synchroniser and edge history. The history flop tracks the synchronised
  // level in every state, so edges seen while waiting or while run = 0 are
  // consumed and never replayed later.
  // ---------------------------------------------------------------------------
  assign sync_val  = sync_q[SYNC_STAGES-1];
  assign tick_edge = sync_val ^ hist_q;

  // NOTE: sequential state is written with non-blocking assignments so every
  // flop samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], tick_in};
      hist_q <= sync_val;
    end
  end

  assign sec_tick   = tick_edge & run & (state == ST_RUN);
  assign set_accept = set_valid & set_ready;
  assign set_legal  = (set_sec <= MS_LAST) && (set_min <= MS_LAST) &&
                      (set_hour <= HOUR_LAST);

  // ---------------------------------------------------------------------------
  // Next time after one second. All carries resolve here so the registers
  // jump straight to the wrapped value in a single cycle.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output is given a value on every path (defaults
  // first) so no latch is inferred.
  always_comb begin
    sec_wrap = (sec == MS_LAST);
    min_wrap = (min == MS_LAST);
    day_wrap = sec_wrap && min_wrap && (hour == HOUR_LAST);
    sec_nxt  = sec + 6'd1;
    min_nxt  = min;
    hour_nxt = hour;
    if (sec_wrap) begin
      sec_nxt = 6'd0;
      min_nxt = min + 6'd1;
      if (min_wrap) begin
        min_nxt  = 6'd0;
        hour_nxt = (hour == HOUR_LAST) ? 5'd0 : hour + 5'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM with registered outputs. WAIT_SYNC lets the synchroniser and
  // history fill after reset so the tick_in level at reset is not a tick.
  // An accepted set request takes priority over a coincident tick, which is
  // dropped whether or not the set value was legal.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_WAIT_SYNC;
      wait_cnt  <= 3'd0;
      set_ready <= 1'b0;
      set_err   <= 1'b0;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
      hour      <= 5'd0;
      min       <= 6'd0;
      sec       <= 6'd0;
`ifdef TICK_TIME_COUNTER_ALARM_EN
      alarm_hit <= 1'b0;
`endif
    end else begin
      set_err   <= 1'b0;
      sec_pulse <= 1'b0;
      day_pulse <= 1'b0;
`ifdef TICK_TIME_COUNTER_ALARM_EN
      alarm_hit <= 1'b0;
`endif
      case (state)
        ST_WAIT_SYNC: begin
          if (wait_cnt == WAIT_LAST) begin
            state     <= ST_RUN;
            set_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        ST_RUN: begin
          if (set_accept) begin
            if (set_legal) begin
              hour <= set_hour;
              min  <= set_min;
              sec  <= set_sec;
            end else begin
              set_err <= 1'b1;
            end
          end else if (sec_tick) begin
            hour      <= hour_nxt;
            min       <= min_nxt;
            sec       <= sec_nxt;
            sec_pulse <= 1'b1;
            day_pulse <= day_wrap;
`ifdef TICK_TIME_COUNTER_ALARM_EN
            alarm_hit <= alarm_arm && (hour_nxt == alarm_hour) &&
                         (min_nxt == alarm_min) && (sec_nxt == 6'd0);
`endif
          end
        end
        default: begin
          state     <= ST_WAIT_SYNC;
          wait_cnt  <= 3'd0;
          set_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_time_counter.sv
// -----------------------------------------------------------------------------
// tb_tick_time_counter
//
// Self-checking bench for tick_time_counter (default parameters). The time of
// day is modelled as a plain seconds-of-day integer; pulses are counted by a
// negedge monitor and compared as deltas across each operation.
// -----------------------------------------------------------------------------
module tb_tick_time_counter;

  localparam int HOUR_MAX = 24;
  localparam int DAY      = HOUR_MAX * 3600;

  logic       clk_in;
  logic       rst_n;
  logic       tick_in;
  logic       run;
  logic       set_valid;
  logic       set_ready;
  logic [4:0] set_hour;
  logic [5:0] set_min;
  logic [5:0] set_sec;
  logic       set_err;
  logic [4:0] hour;
  logic [5:0] min;
  logic [5:0] sec;
  logic       sec_pulse;
  logic       day_pulse;
`ifdef TICK_TIME_COUNTER_ALARM_EN
  logic       alarm_arm;
  logic [4:0] alarm_hour;
  logic [5:0] alarm_min;
  logic       alarm_hit;
`endif

  tick_time_counter #(.SYNC_STAGES(2), .HOUR_MAX(HOUR_MAX)) dut (
    .clk_in    (clk_in),
    .rst_n     (rst_n),
    .tick_in   (tick_in),
    .run       (run),
    .set_valid (set_valid),
    .set_ready (set_ready),
    .set_hour  (set_hour),
    .set_min   (set_min),
    .set_sec   (set_sec),
    .set_err   (set_err),
`ifdef TICK_TIME_COUNTER_ALARM_EN
    .alarm_arm (alarm_arm),
    .alarm_hour(alarm_hour),
    .alarm_min (alarm_min),
    .alarm_hit (alarm_hit),
`endif
    .hour      (hour),
    .min       (min),
    .sec       (sec),
    .sec_pulse (sec_pulse),
    .day_pulse (day_pulse)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int checks   = 0;
  int failures = 0;

  // Pulse monitors, sampled on the inactive edge.
  int n_sec   = 0;
  int n_day   = 0;
  int n_err   = 0;
  int n_alarm = 0;
  always @(negedge clk_in) begin
    if (sec_pulse === 1'b1) n_sec++;
    if (day_pulse === 1'b1) n_day++;
    if (set_err   === 1'b1) n_err++;
`ifdef TICK_TIME_COUNTER_ALARM_EN
    if (alarm_hit === 1'b1) n_alarm++;
`endif
  end

  int ps, pd, pe, pa;
  int model_t;

  logic [4:0] seen_h;
  logic [5:0] seen_m;
  logic [5:0] seen_s;
  logic       seen_err;

  typedef struct {
    logic [4:0] h;
    logic [5:0] m;
    logic [5:0] s;
    logic       err;
    logic [4:0] eh;
    logic [5:0] em;
    logic [5:0] es;
  } set_vec_t;

  set_vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic check_time(input string tag);
    check({tag, "_hour"}, 32'(hour), 32'(model_t / 3600));
    check({tag, "_min"},  32'(min),  32'((model_t / 60) % 60));
    check({tag, "_sec"},  32'(sec),  32'(model_t % 60));
  endtask

  task automatic snap();
    ps = n_sec;
    pd = n_day;
    pe = n_err;
    pa = n_alarm;
  endtask

  // One tick_in edge with the given run level; returns well after the update.
  task automatic do_tick(input logic run_val);
    @(posedge clk_in);
    #1;
    run     = run_val;
    tick_in = ~tick_in;
    repeat (4) @(posedge clk_in);
    #1;
  endtask

  // One set request; records the outputs on the cycle after acceptance.
  task automatic do_set(input logic [4:0] h, input logic [5:0] m, input logic [5:0] s);
    @(posedge clk_in);
    #1;
    set_hour  = h;
    set_min   = m;
    set_sec   = s;
    set_valid = 1'b1;
    @(posedge clk_in);
    @(negedge clk_in);
    seen_h    = hour;
    seen_m    = min;
    seen_s    = sec;
    seen_err  = set_err;
    set_valid = 1'b0;
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got time %0t expected finish before 500000", $time);
    $fatal(1);
  end

  initial begin
    logic [4:0] rh;
    logic [5:0] rm;
    logic [5:0] rs;
    logic       rrun;
    logic       legal;
    int         op;
    int         hold_t;

    vecs[0] = '{5'd12, 6'd60, 6'd0,  1'b1, 5'd0,  6'd0,  6'd1};
    vecs[1] = '{5'd12, 6'd34, 6'd56, 1'b0, 5'd12, 6'd34, 6'd56};
    vecs[2] = '{5'd24, 6'd0,  6'd0,  1'b1, 5'd12, 6'd34, 6'd56};
    vecs[3] = '{5'd0,  6'd0,  6'd60, 1'b1, 5'd12, 6'd34, 6'd56};
    vecs[4] = '{5'd23, 6'd59, 6'd59, 1'b0, 5'd23, 6'd59, 6'd59};
    vecs[5] = '{5'd0,  6'd0,  6'd0,  1'b0, 5'd0,  6'd0,  6'd0};
    vecs[6] = '{5'd31, 6'd63, 6'd63, 1'b1, 5'd0,  6'd0,  6'd0};
    vecs[7] = '{5'd5,  6'd59, 6'd59, 1'b0, 5'd5,  6'd59, 6'd59};

    rst_n     = 1'b0;
    tick_in   = 1'b1;
    run       = 1'b1;
    set_valid = 1'b0;
    set_hour  = 5'd0;
    set_min   = 6'd0;
    set_sec   = 6'd0;
`ifdef TICK_TIME_COUNTER_ALARM_EN
    alarm_arm  = 1'b0;
    alarm_hour = 5'd0;
    alarm_min  = 6'd0;
`endif
    model_t = 0;

    // Reset state
    repeat (3) @(posedge clk_in);
    #1;
    check_time("reset");
    check("reset_set_ready", 32'(set_ready), 0);
    check("reset_set_err",   32'(set_err),   0);
    check("reset_sec_pulse", 32'(sec_pulse), 0);
    check("reset_day_pulse", 32'(day_pulse), 0);

    // Release with tick_in high and an illegal set request while not ready
    snap();
    rst_n     = 1'b1;
    set_hour  = 5'd31;
    set_min   = 6'd63;
    set_sec   = 6'd63;
    set_valid = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    set_valid = 1'b0;
    repeat (18) @(posedge clk_in);
    #1;
    check_time("settle");
    check("settle_no_sec_pulse", 32'(n_sec - ps), 0);
    check("settle_no_set_err",   32'(n_err - pe), 0);
    check("settle_set_ready",    32'(set_ready),  1);

    // Latency: toggle lands on sec exactly three cycles later
    tick_in = 1'b0;
    repeat (2) @(posedge clk_in);
    @(negedge clk_in);
    check("latency_sec_before", 32'(sec), 0);
    @(posedge clk_in);
    @(negedge clk_in);
    check("latency_sec_at",       32'(sec),       1);
    check("latency_sec_pulse_at", 32'(sec_pulse), 1);
    @(posedge clk_in);
    @(negedge clk_in);
    check("latency_sec_pulse_after", 32'(sec_pulse), 0);
    model_t = 1;

    // Set vectors
    for (int i = 0; i < 8; i++) begin
      snap();
      do_set(vecs[i].h, vecs[i].m, vecs[i].s);
      check($sformatf("vec%0d_err", i),      32'(seen_err),    32'(vecs[i].err));
      check($sformatf("vec%0d_err_cnt", i),  32'(n_err - pe),  32'(vecs[i].err));
      check($sformatf("vec%0d_hour", i),     32'(seen_h),      32'(vecs[i].eh));
      check($sformatf("vec%0d_min", i),      32'(seen_m),      32'(vecs[i].em));
      check($sformatf("vec%0d_sec", i),      32'(seen_s),      32'(vecs[i].es));
      check($sformatf("vec%0d_no_tick", i),  32'(n_sec - ps),  0);
      model_t = int'(vecs[i].eh) * 3600 + int'(vecs[i].em) * 60 + int'(vecs[i].es);
    end

    // Day wrap
    do_set(5'd23, 6'd59, 6'd58);
    model_t = DAY - 2;
    snap();
    do_tick(1'b1);
    model_t = DAY - 1;
    check_time("wrap_first");
    check("wrap_first_day_cnt", 32'(n_day - pd), 0);
    snap();
    do_tick(1'b1);
    model_t = 0;
    check_time("wrap");
    check("wrap_day_cnt", 32'(n_day - pd), 1);
    check("wrap_sec_cnt", 32'(n_sec - ps), 1);

    // Legal set coinciding with a tick: set wins, tick dropped
    snap();
    @(posedge clk_in);
    #1;
    tick_in = ~tick_in;
    repeat (2) @(posedge clk_in);
    #1;
    set_hour  = 5'd5;
    set_min   = 6'd0;
    set_sec   = 6'd0;
    set_valid = 1'b1;
    @(posedge clk_in);
    #1;
    set_valid = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    model_t = 5 * 3600;
    check_time("coll_set");
    check("coll_set_no_sec_pulse", 32'(n_sec - ps), 0);
    check("coll_set_no_err",       32'(n_err - pe), 0);
    do_tick(1'b1);
    model_t = 5 * 3600 + 1;
    check_time("coll_next");

    // Illegal set coinciding with a tick: error, tick still dropped
    snap();
    @(posedge clk_in);
    #1;
    tick_in = ~tick_in;
    repeat (2) @(posedge clk_in);
    #1;
    set_min   = 6'd60;
    set_valid = 1'b1;
    @(posedge clk_in);
    #1;
    set_valid = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    check_time("coll_bad");
    check("coll_bad_err_cnt",      32'(n_err - pe), 1);
    check("coll_bad_no_sec_pulse", 32'(n_sec - ps), 0);

    // run = 0 consumes edges; no catch-up on re-enable
    snap();
    for (int i = 0; i < 5; i++) do_tick(1'b0);
    check_time("halt");
    check("halt_sec_cnt", 32'(n_sec - ps), 0);
    run = 1'b1;
    repeat (10) @(posedge clk_in);
    #1;
    check_time("resume_idle");
    check("resume_idle_sec_cnt", 32'(n_sec - ps), 0);
    do_tick(1'b1);
    model_t = model_t + 1;
    check_time("resume_tick");

    // Randomised operations against the seconds-of-day model
    for (int step = 0; step < 200; step++) begin
      op = int'($urandom_range(0, 9));
      snap();
      if (op < 5) begin
        rrun = ($urandom_range(0, 3) != 0);
        hold_t = model_t;
        do_tick(rrun);
        if (rrun) model_t = (model_t + 1) % DAY;
        check($sformatf("rnd%0d_sec_cnt", step), 32'(n_sec - ps), rrun ? 1 : 0);
        check($sformatf("rnd%0d_day_cnt", step), 32'(n_day - pd),
              (rrun && hold_t == DAY - 1) ? 1 : 0);
      end else if (op < 9) begin
        if (op == 8) begin
          rh = 5'($urandom_range(0, 31));
          rm = 6'($urandom_range(50, 63));
          rs = 6'($urandom_range(50, 63));
        end else if ($urandom_range(0, 2) == 0) begin
          rh = 5'(HOUR_MAX - 1);
          rm = 6'd59;
          rs = 6'($urandom_range(55, 59));
        end else begin
          rh = 5'($urandom_range(0, HOUR_MAX - 1));
          rm = 6'($urandom_range(0, 59));
          rs = 6'($urandom_range(0, 59));
        end
        legal = (int'(rh) < HOUR_MAX) && (int'(rm) < 60) && (int'(rs) < 60);
        do_set(rh, rm, rs);
        if (legal) model_t = int'(rh) * 3600 + int'(rm) * 60 + int'(rs);
        check($sformatf("rnd%0d_err_cnt", step), 32'(n_err - pe), legal ? 0 : 1);
      end else begin
        repeat (int'($urandom_range(1, 8))) @(posedge clk_in);
        #1;
        check($sformatf("rnd%0d_idle_sec_cnt", step), 32'(n_sec - ps), 0);
      end
      check_time($sformatf("rnd%0d", step));
    end

`ifdef TICK_TIME_COUNTER_ALARM_EN
    // Alarm at 07:30, armed
    alarm_hour = 5'd7;
    alarm_min  = 6'd30;
    alarm_arm  = 1'b1;
    do_set(5'd7, 6'd29, 6'd58);
    snap();
    do_tick(1'b1);
    check("alarm_early", 32'(n_alarm - pa), 0);
    do_tick(1'b1);
    check("alarm_hit_cnt", 32'(n_alarm - pa), 1);
    model_t = 7 * 3600 + 30 * 60;
    check_time("alarm_at");
    do_tick(1'b1);
    check("alarm_once", 32'(n_alarm - pa), 1);
    model_t = model_t + 1;
    // Disarmed
    alarm_arm = 1'b0;
    do_set(5'd7, 6'd29, 6'd58);
    snap();
    do_tick(1'b1);
    do_tick(1'b1);
    check("alarm_disarmed", 32'(n_alarm - pa), 0);
    // Set onto the alarm time does not fire
    alarm_arm = 1'b1;
    snap();
    do_set(5'd7, 6'd30, 6'd0);
    repeat (3) @(posedge clk_in);
    #1;
    check("alarm_set_no_fire", 32'(n_alarm - pa), 0);
    alarm_arm = 1'b0;
    model_t = 7 * 3600 + 30 * 60;
    check_time("alarm_set");
`endif

    // Asynchronous reset mid-count
    do_set(5'd13, 6'd14, 6'd15);
    model_t = 13 * 3600 + 14 * 60 + 15;
    do_tick(1'b1);
    model_t = model_t + 1;
    check_time("pre_reset");
    @(posedge clk_in);
    #3;
    rst_n = 1'b0;
    #1;
    model_t = 0;
    check_time("async_reset");
    check("async_reset_set_ready", 32'(set_ready), 0);
    check("async_reset_sec_pulse", 32'(sec_pulse), 0);
    check("async_reset_day_pulse", 32'(day_pulse), 0);
    check("async_reset_set_err",   32'(set_err),   0);
    #20;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
